led_scan_controller: RTL and testbench

Sequences the N x N LED array column driver. It time-multiplexes the column index `x` across all N columns, with a programmable dwell period per column and a blanking gap between columns to suppress ghosting. Game-of-life frames arrive from the cell update logic through a valid/ready handshake into a pending buffer. The pending buffer is swapped into the displayed buffer only on a frame boundary, so no frame tearing occurs. The controller sits between the cell state register and the column driver.

---
 rtl/led_scan_controller.sv | 156 +++++++++++++++
 tb/tb_led_scan_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// rtl/led_scan_controller.sv - column scan sequencer with tear-free double-buffered frames
//
// Purpose:
//   Time-multiplexes the column index x across N columns. Each column is driven
//   for DWELL cycles, then the driver is blanked for BLANK cycles. Frames arrive
//   through a valid/ready handshake into a pending buffer. The pending buffer is
//   promoted to the displayed buffer only at a frame boundary or while idle.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   ena          scan enable; low forces IDLE
//   frame_valid  new frame offered
//   frame_data   offered frame, row i = bits [(i+1)*N-1 : i*N]
//   frame_ready  pending buffer can accept a frame
//   drv_ena      enable to the column driver
//   x            column index to the driver
//   cells        displayed frame to the driver
//   frame_done   one-cycle pulse during the last blank cycle of a full scan
module led_scan_controller #(
  parameter int N     = 8,
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  input  logic                              frame_valid,
  input  logic [N*N-1:0]                    frame_data,
  output logic                              frame_ready,
  output logic                              drv_ena,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] x,
  output logic [N*N-1:0]                    cells,
  output logic                              frame_done
);

  localparam int XW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

  if (N < 1 || N > 8) begin : g_bad_n
    $error("led_scan_controller: N must be in 1..8");
  end
  if (DWELL < 1 || BLANK < 1) begin : g_bad_timing
    $error("led_scan_controller: DWELL and BLANK must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK_ST = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic          done_q, done_d;

  logic [N*N-1:0] pending_q;
  logic [N*N-1:0] active_q;
  logic           pending_full_q;
  logic           accept;
  logic           swap;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      done_q  <= done_d;
    end
  end

  // Next-state and outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    drv_ena = (state_q == SCAN);
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      x_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SCAN;
          cnt_d   = '0;
          x_d     = '0;
        end
        SCAN: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = BLANK_ST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BLANK_ST: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SCAN;
            cnt_d   = '0;
            x_d     = (x_q == X_LAST) ? '0 : x_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          x_d     = '0;
        end
      endcase
    end
    // frame_done is registered from the next state so it is high exactly in
    // the final blank cycle of the last column, and never after ena drops.
    done_d = (state_d == BLANK_ST) && (cnt_d == BLANK_LAST) && (x_d == X_LAST);
  end

  assign frame_ready = ~pending_full_q;
  assign accept      = frame_valid & ~pending_full_q;
  // Swap and accept are mutually exclusive: swap needs a full pending buffer,
  // accept needs an empty one.
  assign swap        = pending_full_q & ((state_q == IDLE) | done_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q      <= '0;
      active_q       <= '0;
      pending_full_q <= 1'b0;
    end else begin
      if (accept) begin
        pending_q      <= frame_data;
        pending_full_q <= 1'b1;
      end else if (swap) begin
        active_q       <= pending_q;
        pending_full_q <= 1'b0;
      end
    end
  end

  assign x          = x_q;
  assign cells      = active_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// tb/tb_led_scan_controller.sv - directed self-checking bench for led_scan_controller
module tb_led_scan_controller;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        frame_valid;
  logic [63:0] frame_data;
  logic        frame_ready;
  logic        drv_ena;
  logic [2:0]  x;
  logic [63:0] cells;
  logic        frame_done;

  int checks;
  int errors;
  int cyc;

  localparam logic [63:0] FA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FB = 64'hDEAD_BEEF_0000_FFFF;
  localparam logic [63:0] FD = 64'h1111_2222_3333_4444;
  localparam logic [63:0] FE = 64'hA5A5_5A5A_F0F0_0F0F;
  localparam logic [63:0] FF = 64'h8000_0000_0000_0001;

  led_scan_controller #(.N(8), .DWELL(4), .BLANK(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .drv_ena     (drv_ena),
    .x           (x),
    .cells       (cells),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    rst         = 1'b1;
    ena         = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: post-reset idle
    for (int i = 0; i < 20; i++) begin
      chk("idle_drv",   64'(drv_ena),     64'd0);
      chk("idle_x",     64'(x),           64'd0);
      chk("idle_cells", cells,            64'd0);
      chk("idle_ready", 64'(frame_ready), 64'd1);
      chk("idle_done",  64'(frame_done),  64'd0);
      tick();
    end

    // 2: first frame load while idle, then scan timing
    frame_valid = 1'b1;
    frame_data  = FA;
    tick();
    frame_valid = 1'b0;
    chk("load_ready", 64'(frame_ready), 64'd0);
    ena = 1'b1;
    tick();
    cyc = 0;
    chk("load_cells",  cells,            FA);
    chk("load_ready2", 64'(frame_ready), 64'd1);
    for (int c = 0; c < 80; c++) begin
      chk("scan_drv",  64'(drv_ena),    64'((c % 5) != 4));
      chk("scan_x",    64'(x),          64'((c % 40) / 5));
      chk("scan_done", 64'(frame_done), 64'((c % 40) == 39));
      tick();
    end

    // 3: tear-free swap, frame B offered at x=3
    run_to(95);
    chk("swap_x3", 64'(x), 64'd3);
    frame_valid = 1'b1;
    frame_data  = FB;
    tick();
    frame_valid = 1'b0;
    chk("swap_ready",  64'(frame_ready), 64'd0);
    chk("swap_holdA",  cells,            FA);
    run_to(119);
    chk("swap_done",   64'(frame_done),  64'd1);
    chk("swap_stillA", cells,            FA);
    tick();
    chk("swap_B",      cells,            FB);
    chk("swap_x0",     64'(x),           64'd0);
    chk("swap_drv",    64'(drv_ena),     64'd1);
    chk("swap_ready2", 64'(frame_ready), 64'd1);

    // 4: backpressure, D accepted then E held while pending is full
    frame_valid = 1'b1;
    frame_data  = FD;
    tick();
    frame_data  = FE;
    chk("bp_ready0", 64'(frame_ready), 64'd0);
    run_to(159);
    chk("bp_done",   64'(frame_done),  64'd1);
    chk("bp_ready1", 64'(frame_ready), 64'd0);
    chk("bp_cellsB", cells,            FB);
    tick();
    chk("bp_cellsD", cells,            FD);
    chk("bp_ready2", 64'(frame_ready), 64'd1);
    tick();
    frame_valid = 1'b0;
    chk("bp_takenE", 64'(frame_ready), 64'd0);
    run_to(199);
    chk("bp_stillD", cells,            FD);
    tick();
    chk("bp_cellsE", cells,            FE);

    // 5: frame offered exactly in the frame_done cycle with pending empty
    run_to(239);
    chk("col_done",  64'(frame_done),  64'd1);
    chk("col_ready", 64'(frame_ready), 64'd1);
    frame_valid = 1'b1;
    frame_data  = FF;
    tick();
    frame_valid = 1'b0;
    chk("col_keepE", cells,            FE);
    chk("col_full",  64'(frame_ready), 64'd0);
    run_to(279);
    chk("col_stillE", cells,           FE);
    tick();
    chk("col_cellsF", cells,           FF);

    // 6: ena dropped at x=5 during dwell, then re-raised
    run_to(306);
    chk("ena_x5",   64'(x),       64'd5);
    chk("ena_drv1", 64'(drv_ena), 64'd1);
    ena = 1'b0;
    tick();
    chk("ena_drv0",  64'(drv_ena),    64'd0);
    chk("ena_xclr",  64'(x),          64'd0);
    chk("ena_done",  64'(frame_done), 64'd0);
    chk("ena_cells", cells,           FF);
    repeat (3) tick();
    chk("ena_idle_drv", 64'(drv_ena), 64'd0);
    ena = 1'b1;
    tick();
    chk("ena_re_drv",   64'(drv_ena), 64'd1);
    chk("ena_re_x",     64'(x),       64'd0);
    chk("ena_re_cells", cells,        FF);

    // async reset mid-dwell, observed before the next clock edge
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_drv",   64'(drv_ena),     64'd0);
    chk("rst_x",     64'(x),           64'd0);
    chk("rst_cells", cells,            64'd0);
    chk("rst_ready", 64'(frame_ready), 64'd1);
    chk("rst_done",  64'(frame_done),  64'd0);
    tick();
    rst = 1'b0;
    ena = 1'b0;
    tick();
    chk("rst_after_cells", cells, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
